narrow_cfg_master: RTL and testbench
====================================

NARROW_CFG_MASTER -- requirements
Module: narrow_cfg_master

Interface
- REQ-001: Parameter NumReq, default 2: number of requesters.
- REQ-002: Parameter AddrWidth, default 48: AXI address width.
- REQ-003: Parameter DataWidth, default 64: AXI data width.
- REQ-004: Parameter TimeoutCycles, default 1024: watchdog limit per phase.
- REQ-005: Parameters req_t and rsp_t, no default: narrow AXI request and response struct types.
- REQ-006: clk  in  1  clock.
- REQ-007: rst_n  in  1  reset, asynchronous, active-high.
- REQ-008: rq_valid_i  in  NumReq  per-requester command valid.
- REQ-009: rq_ready_o  out  NumReq  per-requester command accepted (grant).
- REQ-010: rq_write_i  in  NumReq  1=write, 0=read.
- REQ-011: rq_addr_i  in  NumReq x AddrWidth  target address.
- REQ-012: rq_wdata_i  in  NumReq x DataWidth  write data.
- REQ-013: rs_valid_o  out  NumReq  one-cycle completion pulse to the owner.
- REQ-014: rs_rdata_o  out  DataWidth  read data, shared, valid with rs_valid_o.
- REQ-015: rs_err_o  out  1  completion response not OKAY.
- REQ-016: axi_req_o  out  req_t  AXI master request.
- REQ-017: axi_rsp_i  in  rsp_t  AXI master response.
- REQ-018: timeout_o  out  1  sticky watchdog flag.

Function
- REQ-019: FSM states are IDLE, AW, W, B, AR, R; one transaction is outstanding at most.
- REQ-020: In IDLE with any rq_valid_i set, round-robin arbitration grants one requester.
  - Pointer starts after the last grant; after reset it starts at index 0.
  - rq_ready_o pulses for exactly one cycle to the winner.
  - Command is latched; the next state is AW for a write, AR for a read.
- REQ-021: AW drives aw_valid, addr, size=$clog2(DataWidth/8), id=0, len=0, burst=INCR, and holds them until aw_ready; then goes to W.
- REQ-022: W drives w_valid, data, strb all ones, last=1, and holds until w_ready; then goes to B.
- REQ-023: B drives b_ready=1 and waits for b_valid; then:
  - pulses rs_valid_o[owner];
  - sets rs_err_o = (b.resp != OKAY);
  - returns to IDLE.
- REQ-024: AR drives ar_valid and fields as in AW, holds until ar_ready, then goes to R.
- REQ-025: R drives r_ready=1 and waits for r_valid; then:
  - captures r.data into rs_rdata_o;
  - pulses rs_valid_o[owner];
  - sets rs_err_o = (r.resp != OKAY);
  - returns to IDLE.
- REQ-026: Address/data channel valids never drop before their handshake; unused request fields are 0.
- REQ-027: A new grant occurs no earlier than the cycle after rs_valid_o; the minimum write is 4 cycles and the minimum read is 3 cycles from grant.
- REQ-028: Requests arriving while busy are held pending; a requester deasserting before grant is dropped silently.
- REQ-029: Simultaneous requests are served strictly round-robin; no requester waits more than NumReq-1 transactions.

Reset
- REQ-030: While rst_n is asserted:
  - state=IDLE, arbitration pointer=0;
  - all axi_req_o fields, rq_ready_o, rs_valid_o, rs_rdata_o, rs_err_o and timeout_o are 0.
- REQ-031: Reset mid-transaction abandons the transaction immediately, with no completion pulse.

Configuration
- REQ-032: Macro SNITCH_CFG_MASTER_TIMEOUT_EN controls the watchdog.
  - Defined: a counter restarts on every state change and increments each cycle in AW/W/B/AR/R.
  - On reaching TimeoutCycles it sets timeout_o until reset; the transaction continues, with no protocol abort.
  - Undefined: no counter exists and timeout_o is constant 0.

Structure
- REQ-033: Shared package snitch_cfg_master_pkg holds the state enum and the AXI size/burst constants.
- REQ-034: Sub-module cfg_master_rr_arb implements the round-robin arbiter (NumReq-wide, pointer update on grant).

Verification
- REQ-035: Write 0x8000_0000 to 0x1002_0008 from req0, AXI slave ready at once -> axi_req_o shows AW, then W, then B; rs_valid_o[0] arrives 4 cycles after grant with rs_err_o=0.
- REQ-036: Read 0x1000_0000 from req1 with slave data 0xDEAD_BEEF and 2-cycle ar_ready delay -> rs_rdata_o=0xDEAD_BEEF with rs_valid_o[1]; ar_valid held 3 cycles.
- REQ-037: req0 and req1 valid together for 4 transactions -> grants in order 0,1,0,1.
- REQ-038: b.resp=SLVERR -> rs_err_o=1 with the pulse; the next OKAY transaction gives rs_err_o=0.
- REQ-039: rst_n asserted while in W -> next cycle IDLE, all outputs 0, no rs_valid_o.
- REQ-040: With SNITCH_CFG_MASTER_TIMEOUT_EN defined and TimeoutCycles=8, aw_ready withheld 10 cycles -> timeout_o rises at cycle 8 and the write still completes.

Source files
------------

// File: rtl/snitch_cfg_master_pkg.sv
`default_nettype none
// ============================================================================
// Package : snitch_cfg_master_pkg
// Brief   : Shared state encoding, AXI constants and default narrow AXI
//           request/response types for narrow_cfg_master.
// Rev     : 1.0 - initial release
// ============================================================================
package snitch_cfg_master_pkg;

  // One transaction in flight at most; each AXI phase has its own state.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAw   = 3'd1,
    StW    = 3'd2,
    StB    = 3'd3,
    StAr   = 3'd4,
    StR    = 3'd5
  } state_e;

  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespSlvErr = 2'b10;

  // AXI size field for a full-width beat of data_width bits.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  // Default narrow AXI channel types (48-bit address, 64-bit data).
  typedef struct packed {
    logic [3:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } narrow_ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } narrow_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } narrow_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } narrow_r_chan_t;

  typedef struct packed {
    narrow_ax_chan_t aw;
    logic            aw_valid;
    narrow_w_chan_t  w;
    logic            w_valid;
    logic            b_ready;
    narrow_ax_chan_t ar;
    logic            ar_valid;
    logic            r_ready;
  } narrow_req_t;

  typedef struct packed {
    logic           aw_ready;
    logic           ar_ready;
    logic           w_ready;
    logic           b_valid;
    narrow_b_chan_t b;
    logic           r_valid;
    narrow_r_chan_t r;
  } narrow_rsp_t;

endpackage
`default_nettype wire

// File: rtl/cfg_master_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : cfg_master_rr_arb
// Brief  : NumReq-wide round-robin arbiter. Search starts one past the last
//          winner; the pointer only moves when a grant is actually issued.
// Rev    : 1.0 - initial release
// ============================================================================
module cfg_master_rr_arb #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic            found;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand = IdxW'((int'(ptr_q) + i) % int'(NumReq));
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // Pointer register; reset places priority on requester 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/narrow_cfg_master.sv
`default_nettype none
// ============================================================================
// Module : narrow_cfg_master
// Brief  : Arbitrates NumReq single-beat config commands onto one narrow AXI
//          master port, one transaction at a time, with registered outputs.
// Config : SNITCH_CFG_MASTER_TIMEOUT_EN enables the per-phase watchdog that
//          drives the sticky timeout_o flag; otherwise timeout_o is 0.
// Rev    : 1.0 - initial release
// ============================================================================
module narrow_cfg_master import snitch_cfg_master_pkg::*; #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         req_t         = narrow_req_t,
  parameter type         rsp_t         = narrow_rsp_t
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumReq-1:0]                  rq_valid_i,
  output logic [NumReq-1:0]                  rq_ready_o,
  input  logic [NumReq-1:0]                  rq_write_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]   rq_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   rq_wdata_i,
  output logic [NumReq-1:0]                  rs_valid_o,
  output logic [DataWidth-1:0]               rs_rdata_o,
  output logic                               rs_err_o,
  output req_t                               axi_req_o,
  input  rsp_t                               axi_rsp_i,
  output logic                               timeout_o
);

  localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [2:0]  AxiSize = axi_size(DataWidth);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  req_t                   axi_req_q, axi_req_d;
  logic [NumReq-1:0]      rs_valid_q, rs_valid_d;
  logic [DataWidth-1:0]   rs_rdata_q, rs_rdata_d;
  logic                   rs_err_q, rs_err_d;

  logic                   arb_en;
  logic [NumReq-1:0]      gnt;
  logic [IdxW-1:0]        gnt_idx;

  // No grant while busy, in the completion-pulse cycle, or under reset.
  assign arb_en = (state_q == StIdle) && (rs_valid_q == '0) && !rst_n;

  cfg_master_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (arb_en),
    .req_i (rq_valid_i),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Next state and next (registered) AXI/completion outputs per phase.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wdata_d    = wdata_q;
    axi_req_d  = axi_req_q;
    rs_valid_d = '0;
    rs_rdata_d = rs_rdata_q;
    rs_err_d   = rs_err_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != '0) begin
          owner_d   = gnt_idx;
          wdata_d   = rq_wdata_i[gnt_idx];
          axi_req_d = '0;
          if (rq_write_i[gnt_idx]) begin
            state_d            = StAw;
            axi_req_d.aw_valid = 1'b1;
            axi_req_d.aw.addr  = rq_addr_i[gnt_idx];
            axi_req_d.aw.size  = AxiSize;
            axi_req_d.aw.burst = AxiBurstIncr;
          end else begin
            state_d            = StAr;
            axi_req_d.ar_valid = 1'b1;
            axi_req_d.ar.addr  = rq_addr_i[gnt_idx];
            axi_req_d.ar.size  = AxiSize;
            axi_req_d.ar.burst = AxiBurstIncr;
          end
        end
      end
      StAw: begin
        if (axi_rsp_i.aw_ready) begin
          state_d           = StW;
          axi_req_d         = '0;
          axi_req_d.w_valid = 1'b1;
          axi_req_d.w.data  = wdata_q;
          axi_req_d.w.strb  = '1;
          axi_req_d.w.last  = 1'b1;
        end
      end
      StW: begin
        if (axi_rsp_i.w_ready) begin
          state_d           = StB;
          axi_req_d         = '0;
          axi_req_d.b_ready = 1'b1;
        end
      end
      StB: begin
        if (axi_rsp_i.b_valid) begin
          state_d             = StIdle;
          axi_req_d           = '0;
          rs_valid_d[owner_q] = 1'b1;
          rs_err_d            = (axi_rsp_i.b.resp != AxiRespOkay);
        end
      end
      StAr: begin
        if (axi_rsp_i.ar_ready) begin
          state_d           = StR;
          axi_req_d         = '0;
          axi_req_d.r_ready = 1'b1;
        end
      end
      StR: begin
        if (axi_rsp_i.r_valid) begin
          state_d             = StIdle;
          axi_req_d           = '0;
          rs_valid_d[owner_q] = 1'b1;
          rs_rdata_d          = axi_rsp_i.r.data;
          rs_err_d            = (axi_rsp_i.r.resp != AxiRespOkay);
        end
      end
      default: begin
        state_d   = StIdle;
        axi_req_d = '0;
      end
    endcase
  end

  // FSM and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      wdata_q    <= '0;
      axi_req_q  <= '0;
      rs_valid_q <= '0;
      rs_rdata_q <= '0;
      rs_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wdata_q    <= wdata_d;
      axi_req_q  <= axi_req_d;
      rs_valid_q <= rs_valid_d;
      rs_rdata_q <= rs_rdata_d;
      rs_err_q   <= rs_err_d;
    end
  end

  assign rq_ready_o = gnt;
  assign rs_valid_o = rs_valid_q;
  assign rs_rdata_o = rs_rdata_q;
  assign rs_err_o   = rs_err_q;
  assign axi_req_o  = axi_req_q;

  // Response fields this single-ID, single-beat master never looks at.
  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.r.id, axi_rsp_i.r.last};

`ifdef SNITCH_CFG_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  // Count cycles spent in the current busy phase; flag sticks at the limit.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if ((state_q != StIdle) && (wd_cnt_q != CntW'(TimeoutCycles))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if (wd_cnt_d == CntW'(TimeoutCycles)) timeout_d = 1'b1;
  end

  // Watchdog registers; only reset clears the flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_narrow_cfg_master.sv
`default_nettype none
// ============================================================================
// Module : tb_narrow_cfg_master
// Brief  : Directed self-checking bench for narrow_cfg_master.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_narrow_cfg_master;
  import snitch_cfg_master_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [1:0]        rq_valid;
  logic [1:0]        rq_ready_o;
  logic [1:0]        rq_write;
  logic [1:0][47:0]  rq_addr;
  logic [1:0][63:0]  rq_wdata;
  logic [1:0]        rs_valid_o;
  logic [63:0]       rs_rdata_o;
  logic              rs_err_o;
  narrow_req_t       axi_req_o;
  narrow_rsp_t       rsp;
  logic              timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  narrow_cfg_master #(
    .NumReq        (2),
    .AddrWidth     (48),
    .DataWidth     (64),
    .TimeoutCycles (8),
    .req_t         (narrow_req_t),
    .rsp_t         (narrow_rsp_t)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rq_valid_i (rq_valid),
    .rq_ready_o (rq_ready_o),
    .rq_write_i (rq_write),
    .rq_addr_i  (rq_addr),
    .rq_wdata_i (rq_wdata),
    .rs_valid_o (rs_valid_o),
    .rs_rdata_o (rs_rdata_o),
    .rs_err_o   (rs_err_o),
    .axi_req_o  (axi_req_o),
    .axi_rsp_i  (rsp),
    .timeout_o  (timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for a grant to requester idx, then drop its valid.
  task automatic wait_grant(input logic idx);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (rq_ready_o[idx]) seen = 1'b1;
      else step();
    end
    check("grant_seen", 64'(seen), 64'd1);
    step();
    rq_valid[idx] = 1'b0;
  endtask

  // Wait (bounded) for the completion pulse and return what came with it.
  task automatic wait_done(output logic [1:0] vld, output logic err, output logic [63:0] rdata);
    bit seen;
    seen = 1'b0;
    vld = '0; err = 1'b0; rdata = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (rs_valid_o != '0) begin
        seen = 1'b1; vld = rs_valid_o; err = rs_err_o; rdata = rs_rdata_o;
      end else begin
        step();
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic do_txn(input logic idx, input logic wr, input logic [47:0] addr,
                        input logic [63:0] data, output logic [1:0] vld,
                        output logic err, output logic [63:0] rdata);
    rq_valid[idx] = 1'b1;
    rq_write[idx] = wr;
    rq_addr[idx]  = addr;
    rq_wdata[idx] = data;
    #1;
    wait_grant(idx);
    wait_done(vld, err, rdata);
  endtask

  initial begin
    logic [1:0]  vld;
    logic        err;
    logic [63:0] rdata;
    logic [1:0]  got;
    logic [1:0]  rs_seen;

    rst_n = 1'b1;
    rq_valid = '0; rq_write = '0; rq_addr = '0; rq_wdata = '0;
    rsp = '0;
    rsp.aw_ready = 1'b1; rsp.w_ready = 1'b1; rsp.ar_ready = 1'b1;
    rsp.b_valid = 1'b1; rsp.r_valid = 1'b1;

    // Reset state, with a request pending that must not be granted.
    step();
    rq_valid = 2'b11;
    #1;
    check("rst_rq_ready", 64'(rq_ready_o), 64'd0);
    check("rst_axi_req", 64'(|axi_req_o), 64'd0);
    check("rst_rs_valid", 64'(rs_valid_o), 64'd0);
    check("rst_rs_rdata", rs_rdata_o, 64'd0);
    check("rst_rs_err", 64'(rs_err_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    rq_valid = '0;
    step();
    rst_n = 1'b0;
    step();

    // Write 0x8000_0000 to 0x1002_0008 from req0, slave always ready.
    rq_valid[0] = 1'b1; rq_write[0] = 1'b1;
    rq_addr[0] = 48'h0000_1002_0008; rq_wdata[0] = 64'h8000_0000;
    #1;
    check("wr_grant", 64'(rq_ready_o), 64'd1);
    step();
    rq_valid[0] = 1'b0;
    check("wr_aw_valid", 64'(axi_req_o.aw_valid), 64'd1);
    check("wr_aw_addr", 64'(axi_req_o.aw.addr), 64'h1002_0008);
    check("wr_aw_size", 64'(axi_req_o.aw.size), 64'd3);
    check("wr_aw_burst", 64'(axi_req_o.aw.burst), 64'd1);
    check("wr_aw_len_id", 64'({axi_req_o.aw.len, axi_req_o.aw.id}), 64'd0);
    check("wr_aw_no_w", 64'(axi_req_o.w_valid), 64'd0);
    check("wr_no_regrant", 64'(rq_ready_o), 64'd0);
    step();
    check("wr_w_valid", 64'(axi_req_o.w_valid), 64'd1);
    check("wr_aw_dropped", 64'(axi_req_o.aw_valid), 64'd0);
    check("wr_w_data", axi_req_o.w.data, 64'h8000_0000);
    check("wr_w_strb_last", 64'({axi_req_o.w.strb, axi_req_o.w.last}), 64'h1FF);
    step();
    check("wr_b_ready", 64'(axi_req_o.b_ready), 64'd1);
    check("wr_b_no_w", 64'(axi_req_o.w_valid), 64'd0);
    check("wr_b_no_rs", 64'(rs_valid_o), 64'd0);
    step();
    check("wr_rs_valid", 64'(rs_valid_o), 64'd1);
    check("wr_rs_err", 64'(rs_err_o), 64'd0);
    check("wr_idle_req", 64'(|axi_req_o), 64'd0);

    // Read 0x1000_0000 from req1, ar_ready held off for two cycles.
    rsp.ar_ready = 1'b0;
    rsp.r.data = 64'hDEAD_BEEF;
    rq_valid[1] = 1'b1; rq_write[1] = 1'b0; rq_addr[1] = 48'h0000_1000_0000;
    #1;
    check("rd_no_grant_on_rs", 64'(rq_ready_o), 64'd0);
    wait_grant(1'b1);
    check("rd_ar_valid_1", 64'(axi_req_o.ar_valid), 64'd1);
    check("rd_ar_addr", 64'(axi_req_o.ar.addr), 64'h1000_0000);
    check("rd_ar_size", 64'(axi_req_o.ar.size), 64'd3);
    step();
    check("rd_ar_valid_2", 64'(axi_req_o.ar_valid), 64'd1);
    step();
    check("rd_ar_valid_3", 64'(axi_req_o.ar_valid), 64'd1);
    rsp.ar_ready = 1'b1;
    step();
    check("rd_ar_dropped", 64'(axi_req_o.ar_valid), 64'd0);
    check("rd_r_ready", 64'(axi_req_o.r_ready), 64'd1);
    step();
    check("rd_rs_valid", 64'(rs_valid_o), 64'd2);
    check("rd_rs_rdata", rs_rdata_o, 64'hDEAD_BEEF);
    check("rd_rs_err", 64'(rs_err_o), 64'd0);

    // Both requesters valid for four reads: strict alternation from req0.
    rq_valid = 2'b11; rq_write = 2'b00;
    #1;
    for (int k = 0; k < 4; k++) begin
      got = '0;
      for (int c = 0; c < 20; c++) begin
        if (rs_valid_o != '0) check("rr_no_grant_on_rs", 64'(rq_ready_o), 64'd0);
        if (rq_ready_o != '0) begin
          got = rq_ready_o;
          break;
        end
        step();
      end
      check("rr_grant", 64'(got), 64'(rr_exp[k]));
      step();
    end
    rq_valid = '0;
    step();
    step();

    // Error responses set rs_err_o; the next OKAY clears it.
    rsp.b.resp = AxiRespSlvErr;
    do_txn(1'b0, 1'b1, 48'h40, 64'h11, vld, err, rdata);
    check("slverr_b_vld", 64'(vld), 64'd1);
    check("slverr_b_err", 64'(err), 64'd1);
    rsp.b.resp = AxiRespOkay;
    do_txn(1'b1, 1'b1, 48'h48, 64'h22, vld, err, rdata);
    check("okay_b_vld", 64'(vld), 64'd2);
    check("okay_b_err", 64'(err), 64'd0);
    rsp.r.resp = AxiRespSlvErr;
    rsp.r.data = 64'h1234_5678_9ABC_DEF0;
    do_txn(1'b0, 1'b0, 48'h50, 64'h0, vld, err, rdata);
    check("slverr_r_err", 64'(err), 64'd1);
    check("slverr_r_data", rdata, 64'h1234_5678_9ABC_DEF0);
    rsp.r.resp = AxiRespOkay;

    // Reset while in W: transaction abandoned, no completion pulse.
    rsp.w_ready = 1'b0;
    rq_valid[0] = 1'b1; rq_write[0] = 1'b1; rq_addr[0] = 48'h60; rq_wdata[0] = 64'h33;
    #1;
    wait_grant(1'b0);
    step();
    check("rst_mid_w_valid", 64'(axi_req_o.w_valid), 64'd1);
    rst_n = 1'b1;
    #1;
    check("rst_mid_async_req", 64'(|axi_req_o), 64'd0);
    step();
    check("rst_mid_req", 64'(|axi_req_o), 64'd0);
    check("rst_mid_rs_valid", 64'(rs_valid_o), 64'd0);
    check("rst_mid_rdata", rs_rdata_o, 64'd0);
    check("rst_mid_err", 64'(rs_err_o), 64'd0);
    rsp.w_ready = 1'b1;
    step();
    rst_n = 1'b0;
    rs_seen = '0;
    for (int c = 0; c < 6; c++) begin
      rs_seen = rs_seen | rs_valid_o;
      step();
    end
    check("rst_mid_no_rs", 64'(rs_seen), 64'd0);

    // Pointer back at 0 after reset: req0 wins a simultaneous request.
    rq_valid = 2'b11; rq_write = 2'b00;
    #1;
    check("rst_ptr_grant", 64'(rq_ready_o), 64'd1);
    step();
    rq_valid = '0;
    wait_done(vld, err, rdata);
    check("rst_ptr_vld", 64'(vld), 64'd1);
    step();

`ifdef SNITCH_CFG_MASTER_TIMEOUT_EN
    // aw_ready withheld 10 cycles with an 8-cycle watchdog.
    rsp.aw_ready = 1'b0;
    rq_valid[0] = 1'b1; rq_write[0] = 1'b1; rq_addr[0] = 48'h70; rq_wdata[0] = 64'h44;
    #1;
    wait_grant(1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 8) check("wd_before_limit", 64'(timeout_o), 64'd0);
      if (k == 9) check("wd_at_limit", 64'(timeout_o), 64'd1);
      step();
    end
    rsp.aw_ready = 1'b1;
    wait_done(vld, err, rdata);
    check("wd_write_completes", 64'(vld), 64'd1);
    check("wd_sticky", 64'(timeout_o), 64'd1);
    step();
`else
    check("wd_disabled", 64'(timeout_o), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
